// File: rtl/sc_cracker.sv
// sc_cracker: brute-force driver for the 3-digit button safe.
// Walks every code {d0,d1,d2} with digits 1..15, pressing d0, d1, d2 with a
// reset pulse in front of each attempt, and stops on the first code that
// unlocks the safe or after the last code 0xFFF.
//
// Control handshake: start is a single-cycle request that is only accepted in
// IDLE with stop low; while busy = 1 it is ignored. stop is a level abort that
// is honoured in every non-IDLE state and always wins over start. There is no
// back-pressure: done/found/code/attempts stay valid from the cycle done rises
// until the next accepted start.
module sc_cracker #(
  parameter int GAP_CYC    = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        tgt_unlocked,
  output logic        tgt_rst,
  output logic [3:0]  tgt_btn,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [11:0] code,
  output logic [11:0] attempts
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARST    = 3'd1,
    GAP     = 3'd2,
    PRESS   = 3'd3,
    SETTLE  = 3'd4,
    FOUND   = 3'd5,
    EXHAUST = 3'd6
  } state_t;

  // Terminal values of the shared cycle counter in GAP and SETTLE.
  localparam logic [7:0] GAP_LAST    = 8'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [7:0] SETTLE_LAST = 8'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  // With no gap the press sequence runs back to back.
  localparam state_t     PRE_PRESS   = (GAP_CYC == 0) ? PRESS : GAP;

  state_t      state, state_n;
  logic [1:0]  k, k_n;
  logic [7:0]  cnt, cnt_n;
  logic [11:0] code_n, attempts_n;
  logic        busy_n, done_n, found_n, tgt_rst_n;
  logic [3:0]  tgt_btn_n;

  // Mixed-radix increment over digits 1..15, d2 least significant.
  function automatic logic [11:0] next_code(input logic [11:0] c);
    logic [3:0] d0, d1, d2;
    d0 = c[11:8];
    d1 = c[7:4];
    d2 = c[3:0];
    if (d2 != 4'hF) begin
      d2 = d2 + 4'd1;
    end else begin
      d2 = 4'd1;
      if (d1 != 4'hF) begin
        d1 = d1 + 4'd1;
      end else begin
        d1 = 4'd1;
        d0 = (d0 == 4'hF) ? 4'd1 : d0 + 4'd1;
      end
    end
    return {d0, d1, d2};
  endfunction

  // Digit k of a code, in press order d0, d1, d2.
  function automatic logic [3:0] digit_of(input logic [11:0] c, input logic [1:0] idx);
    case (idx)
      2'd0:    return c[11:8];
      2'd1:    return c[7:4];
      default: return c[3:0];
    endcase
  endfunction

  // Next-state, datapath and next-output logic; outputs are derived from the
  // next state so that the registered outputs line up with the state they belong to.
  always_comb begin
    state_n    = state;
    k_n        = k;
    cnt_n      = cnt;
    code_n     = code;
    attempts_n = attempts;
    busy_n     = busy;
    done_n     = done;
    found_n    = found;
    tgt_rst_n  = 1'b0;
    tgt_btn_n  = 4'd0;

    if (state != IDLE && stop) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      found_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state_n    = ARST;
            code_n     = 12'h111;
            attempts_n = 12'd0;
            done_n     = 1'b0;
            found_n    = 1'b0;
            busy_n     = 1'b1;
          end
        end
        ARST: begin
          k_n     = 2'd0;
          cnt_n   = 8'd0;
          state_n = PRE_PRESS;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state_n = PRESS;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        PRESS: begin
          cnt_n = 8'd0;
          if (k == 2'd2) begin
            state_n = SETTLE;
          end else begin
            k_n     = k + 2'd1;
            state_n = PRE_PRESS;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            attempts_n = attempts + 12'd1;
            if (tgt_unlocked) begin
              state_n = FOUND;
            end else if (code == 12'hFFF) begin
              state_n = EXHAUST;
            end else begin
              code_n  = next_code(code);
              state_n = ARST;
            end
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        FOUND, EXHAUST: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    tgt_rst_n = (state_n == ARST);
    if (state_n == PRESS) begin
      tgt_btn_n = digit_of(code_n, k_n);
    end
    if (state_n == FOUND) begin
      busy_n  = 1'b0;
      done_n  = 1'b1;
      found_n = 1'b1;
    end
    if (state_n == EXHAUST) begin
      busy_n  = 1'b0;
      done_n  = 1'b1;
      found_n = 1'b0;
      code_n  = 12'hFFF;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= 2'd0;
      cnt      <= 8'd0;
      code     <= 12'h111;
      attempts <= 12'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      tgt_rst  <= 1'b0;
      tgt_btn  <= 4'd0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      cnt      <= cnt_n;
      code     <= code_n;
      attempts <= attempts_n;
      busy     <= busy_n;
      done     <= done_n;
      found    <= found_n;
      tgt_rst  <= tgt_rst_n;
      tgt_btn  <= tgt_btn_n;
    end
  end

endmodule

// File: tb/tb_sc_cracker.sv
// Testbench for sc_cracker: two instances (default timing and GAP_CYC=0 /
// SETTLE_CYC=1), each attacking a small behavioural model of the button safe.
module tb_sc_cracker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0, stop = 1'b0;
  logic        unl_a, unl_b;
  logic        trst_a, trst_b, busy_a, busy_b, done_a, done_b, found_a, found_b;
  logic [3:0]  btn_a, btn_b;
  logic [11:0] code_a, code_b, att_a, att_b;

  sc_cracker #(.GAP_CYC(1), .SETTLE_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop), .tgt_unlocked(unl_a),
    .tgt_rst(trst_a), .tgt_btn(btn_a), .busy(busy_a), .done(done_a),
    .found(found_a), .code(code_a), .attempts(att_a)
  );

  sc_cracker #(.GAP_CYC(0), .SETTLE_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop), .tgt_unlocked(unl_b),
    .tgt_rst(trst_b), .tgt_btn(btn_b), .busy(busy_b), .done(done_b),
    .found(found_b), .code(code_b), .attempts(att_b)
  );

  // ---------------- safe models ----------------
  logic [3:0] pass_a [3];
  logic [3:0] pass_b [3];
  int   idx_a, idx_b;
  logic ok_a, ok_b, safe_a, safe_b;
  bit   stub = 1'b0;

  always @(posedge clk) begin
    if (rst || trst_a) begin
      idx_a <= 0; ok_a <= 1'b1; safe_a <= 1'b0;
    end else if (btn_a != 4'd0 && idx_a < 3) begin
      ok_a  <= ok_a && (btn_a == pass_a[idx_a]);
      if (idx_a == 2) safe_a <= ok_a && (btn_a == pass_a[2]);
      idx_a <= idx_a + 1;
    end
  end

  always @(posedge clk) begin
    if (rst || trst_b) begin
      idx_b <= 0; ok_b <= 1'b1; safe_b <= 1'b0;
    end else if (btn_b != 4'd0 && idx_b < 3) begin
      ok_b  <= ok_b && (btn_b == pass_b[idx_b]);
      if (idx_b == 2) safe_b <= ok_b && (btn_b == pass_b[2]);
      idx_b <= idx_b + 1;
    end
  end

  assign unl_a = stub ? 1'b0 : safe_a;
  assign unl_b = safe_b;

  // ---------------- DUT select for the shared run task ----------------
  bit use_b = 1'b0;
  logic        m_busy, m_done, m_found, m_trst;
  logic [3:0]  m_btn;
  logic [11:0] m_code, m_att;
  assign m_busy  = use_b ? busy_b  : busy_a;
  assign m_done  = use_b ? done_b  : done_a;
  assign m_found = use_b ? found_b : found_a;
  assign m_trst  = use_b ? trst_b  : trst_a;
  assign m_btn   = use_b ? btn_b   : btn_a;
  assign m_code  = use_b ? code_b  : code_a;
  assign m_att   = use_b ? att_b   : att_a;

  // Reference code increment: via linear index, independent of digit carries.
  function automatic logic [11:0] tb_inc(input logic [11:0] c);
    int n;
    logic [11:0] r;
    n = (int'(c[11:8]) - 1) * 225 + (int'(c[7:4]) - 1) * 15 + (int'(c[3:0]) - 1) + 1;
    r[11:8] = 4'((n / 225) + 1);
    r[7:4]  = 4'(((n / 15) % 15) + 1);
    r[3:0]  = 4'((n % 15) + 1);
    return r;
  endfunction

  // ---------------- monitors (sampled on the falling edge) ----------------
  int presses_a = 0, presses_b = 0;
  int gap_bad_a = 0, gap_bad_b = 0;
  int since_a = 0, since_b = 0;
  bit armed_a = 1'b0, armed_b = 1'b0;
  int trace_bad = 0, carry1 = 0, carry2 = 0;
  logic [11:0] prev_code_a = 12'h0;
  logic        prev_busy_a = 1'b0;

  always @(negedge clk) begin
    if (btn_a != 4'd0) presses_a++;
    if (trst_a) begin
      since_a = 0; armed_a = 1'b1;
    end else if (armed_a) begin
      since_a++;
      if (btn_a != 4'd0) begin
        if (since_a != 2) gap_bad_a++;
        armed_a = 1'b0;
      end
    end
    if (busy_a && prev_busy_a && code_a != prev_code_a) begin
      if (code_a != tb_inc(prev_code_a)) trace_bad++;
      if (prev_code_a == 12'h11F && code_a == 12'h121) carry1++;
      if (prev_code_a == 12'h1FF && code_a == 12'h211) carry2++;
    end
    prev_code_a = code_a;
    prev_busy_a = busy_a;
  end

  always @(negedge clk) begin
    if (btn_b != 4'd0) presses_b++;
    if (trst_b) begin
      since_b = 0; armed_b = 1'b1;
    end else if (armed_b) begin
      since_b++;
      if (btn_b != 4'd0) begin
        if (since_b != 1) gap_bad_b++;
        armed_b = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver: one full search ----------------
  task automatic run_search(input string tag, input int exp_att, input bit exp_found,
                            input logic [11:0] exp_code, input int len);
    int cyc, p0, g0;
    p0 = use_b ? presses_b : presses_a;
    g0 = use_b ? gap_bad_b : gap_bad_a;
    @(posedge clk); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    check({tag, "_busy_up"}, 32'(m_busy), 32'd1);
    cyc = 0;
    while (m_busy && cyc < 31000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_cycles"}, cyc, exp_att * len);
    check({tag, "_done"}, 32'(m_done), 32'd1);
    check({tag, "_found"}, 32'(m_found), 32'(exp_found));
    check({tag, "_code"}, 32'(m_code), 32'(exp_code));
    check({tag, "_attempts"}, 32'(m_att), exp_att);
    check({tag, "_presses"}, (use_b ? presses_b : presses_a) - p0, 3 * exp_att);
    check({tag, "_rst_to_press"}, (use_b ? gap_bad_b : gap_bad_a) - g0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_hold"}, {31'd0, m_done}, 32'd1);
    check({tag, "_code_hold"}, 32'(m_code), 32'(exp_code));
    check({tag, "_btn_idle"}, 32'(m_btn), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [3:0]  p0, p1, p2;
    bit          stub;
    bit          exp_found;
    logic [11:0] exp_code;
    int          exp_att;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int c1, c2, tb0;
    vecs[0] = '{"dflt_7dd", 4'd7, 4'd13, 4'd13, 1'b0, 1'b1, 12'h7DD, 1543};
    vecs[1] = '{"first_111", 4'd1, 4'd1, 4'd1, 1'b0, 1'b1, 12'h111, 1};
    vecs[2] = '{"second_112", 4'd1, 4'd1, 4'd2, 1'b0, 1'b1, 12'h112, 2};
    vecs[3] = '{"carry_121", 4'd1, 4'd2, 4'd1, 1'b0, 1'b1, 12'h121, 16};
    vecs[4] = '{"carry_211", 4'd2, 4'd1, 4'd1, 1'b0, 1'b1, 12'h211, 226};
    vecs[5] = '{"exhaust", 4'd7, 4'd13, 4'd13, 1'b1, 1'b0, 12'hFFF, 3375};

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tgt_rst", 32'(trst_a), 32'd0);
    check("rst_btn", 32'(btn_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_found", 32'(found_a), 32'd0);
    check("rst_code", 32'(code_a), 32'h111);
    check("rst_attempts", 32'(att_a), 32'd0);
    check("rst_code_b", 32'(code_b), 32'h111);
    rst = 1'b0;

    // table-driven full searches on the default-timing instance
    use_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pass_a[0] = vecs[i].p0; pass_a[1] = vecs[i].p1; pass_a[2] = vecs[i].p2;
      stub = vecs[i].stub;
      c1 = carry1; c2 = carry2; tb0 = trace_bad;
      run_search(vecs[i].name, vecs[i].exp_att, vecs[i].exp_found, vecs[i].exp_code, 9);
      if (vecs[i].stub) begin
        check("trace_11f_121", carry1 - c1, 32'd1);
        check("trace_1ff_211", carry2 - c2, 32'd1);
        check("trace_increment", trace_bad - tb0, 32'd0);
      end
    end
    stub = 1'b0;

    // stop in the middle of attempt 10, with an ignored start during attempt 5
    pass_a[0] = 4'd7; pass_a[1] = 4'd13; pass_a[2] = 4'd13;
    @(posedge clk); #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    for (int c = 1; c <= 84; c++) begin
      @(posedge clk); #1;
      if (c == 40) start_a = 1'b1;
      if (c == 41) start_a = 1'b0;
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("stop_busy", 32'(busy_a), 32'd0);
    check("stop_btn", 32'(btn_a), 32'd0);
    check("stop_tgt_rst", 32'(trst_a), 32'd0);
    check("stop_done", 32'(done_a), 32'd0);
    check("stop_found", 32'(found_a), 32'd0);
    check("stop_attempts", 32'(att_a), 32'd9);
    check("stop_code", 32'(code_a), 32'h11A);
    @(posedge clk); #1;
    check("stop_stays_idle", 32'(busy_a), 32'd0);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("restart_code", 32'(code_a), 32'h111);
    check("restart_attempts", 32'(att_a), 32'd0);
    check("restart_busy", 32'(busy_a), 32'd1);
    check("restart_tgt_rst", 32'(trst_a), 32'd1);
    @(posedge clk); #1;
    check("tgt_rst_one_cycle", 32'(trst_a), 32'd0);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;

    // rst during SETTLE of attempt 3, ignored start during attempt 2
    @(posedge clk); #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (c == 10) start_a = 1'b1;
      if (c == 11) start_a = 1'b0;
    end
    check("busy_start_att", 32'(att_a), 32'd2);
    check("busy_start_code", 32'(code_a), 32'h113);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_tgt_rst", 32'(trst_a), 32'd0);
    check("mid_rst_btn", 32'(btn_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_done", 32'(done_a), 32'd0);
    check("mid_rst_found", 32'(found_a), 32'd0);
    check("mid_rst_code", 32'(code_a), 32'h111);
    check("mid_rst_attempts", 32'(att_a), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_idle_busy", 32'(busy_a), 32'd0);
    check("mid_rst_idle_trst", 32'(trst_a), 32'd0);

    // start and stop together in IDLE: stop wins
    start_a = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; stop = 1'b0;
    check("start_stop_busy", 32'(busy_a), 32'd0);
    check("start_stop_trst", 32'(trst_a), 32'd0);
    @(posedge clk); #1;
    check("start_stop_idle", 32'(busy_a), 32'd0);

    // zero-gap, single-settle instance against the default safe code
    use_b = 1'b1;
    pass_b[0] = 4'd7; pass_b[1] = 4'd13; pass_b[2] = 4'd13;
    run_search("gap0_7dd", 1543, 1'b1, 12'h7DD, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
